// File: rtl/supernova_pkg.sv
// Shared Supernova core types and sizing; carries the multi-wide ROB payloads.
package supernova_pkg;

    localparam int unsigned ROB_ENTRIES        = 128;
    localparam int unsigned ROB_IDX_WIDTH      = $clog2(ROB_ENTRIES);
    localparam int unsigned ROB_DISPATCH_WIDTH = 4;
    localparam int unsigned ROB_COMMIT_WIDTH   = 4;
    localparam int unsigned ROB_WB_PORTS       = 4;
    localparam int unsigned ROB_XLEN           = 64;
    localparam int unsigned ROB_PTAG_W         = 7;
    localparam int unsigned ROB_ARCH_W         = 5;
    localparam int unsigned ROB_INSTR_W        = 32;

    typedef struct packed {
        logic [ROB_XLEN-1:0]    pc;
        logic [ROB_INSTR_W-1:0] instr;
        logic [ROB_ARCH_W-1:0]  rd_arch;
        logic [ROB_PTAG_W-1:0]  rd_phys_old;
        logic                   is_branch;
        logic                   is_load;
        logic                   is_store;
    } rob_alloc_t;

    typedef struct packed {
        logic [ROB_ARCH_W-1:0]  rd_arch;
        logic [ROB_PTAG_W-1:0]  rd_phys_old;
        logic [ROB_XLEN-1:0]    result;
        logic [ROB_XLEN-1:0]    pc;
        logic                   is_branch;
        logic                   is_load;
        logic                   is_store;
    } rob_commit_t;

endpackage

// File: rtl/rob_commit_scan.sv
// Prefix scan over the oldest ROB entries: in-order retire mask and head trap detect.
module rob_commit_scan #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] valid_i,
    input  logic [WIDTH-1:0] done_i,
    input  logic [WIDTH-1:0] exc_i,
    output logic [WIDTH-1:0] cmt_valid_c,
    output logic             trap_c
);

    logic run;

    always_comb begin
        cmt_valid_c = '0;
        run         = 1'b1;
        trap_c      = valid_i[0] & done_i[0] & exc_i[0];
        for (int k = 0; k < int'(WIDTH); k++) begin
            run            = run & valid_i[k] & done_i[k] & ~exc_i[k];
            cmt_valid_c[k] = run;
        end
    end

endmodule

// File: rtl/supernova_rob_mw.sv
// Multi-wide reorder buffer: wide in-order allocate, multi-port writeback, in-order
// retire with precise trap at the head.
module supernova_rob_mw
    import supernova_pkg::*;
#(
    parameter int unsigned ENTRIES        = ROB_ENTRIES,
    parameter int unsigned DISPATCH_WIDTH = ROB_DISPATCH_WIDTH,
    parameter int unsigned COMMIT_WIDTH   = ROB_COMMIT_WIDTH,
    parameter int unsigned WB_PORTS       = ROB_WB_PORTS,
    parameter int unsigned XLEN           = ROB_XLEN,
    parameter int unsigned PTAG_W         = ROB_PTAG_W,
    parameter int unsigned IDX_W          = $clog2(ENTRIES)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush_i,
    input  logic [DISPATCH_WIDTH-1:0]              disp_valid_i,
    output logic                                   disp_ready_o,
    input  rob_alloc_t [DISPATCH_WIDTH-1:0]        disp_entry_i,
    output logic [DISPATCH_WIDTH-1:0][IDX_W-1:0]   disp_idx_o,
    input  logic [WB_PORTS-1:0]                    wb_valid_i,
    input  logic [WB_PORTS-1:0][IDX_W-1:0]         wb_idx_i,
    input  logic [WB_PORTS-1:0][XLEN-1:0]          wb_data_i,
    input  logic [WB_PORTS-1:0]                    wb_exc_i,
    input  logic [WB_PORTS-1:0][XLEN-1:0]          wb_cause_i,
    output logic [COMMIT_WIDTH-1:0]                cmt_valid_o,
    output rob_commit_t [COMMIT_WIDTH-1:0]         cmt_entry_o,
    output logic                                   trap_valid_o,
    output logic [XLEN-1:0]                        trap_pc_o,
    output logic [XLEN-1:0]                        trap_cause_o,
    output logic [IDX_W:0]                         count_o,
    output logic                                   empty_o
);

    localparam int unsigned CNT_W = IDX_W + 1;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  exc;
        logic                  is_branch;
        logic                  is_load;
        logic                  is_store;
        logic [ROB_ARCH_W-1:0] rd_arch;
        logic [PTAG_W-1:0]     rd_phys_old;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       result;
        logic [XLEN-1:0]       cause;
    } ent_t;

    ent_t                ent_q [ENTRIES];
    ent_t                ent_d [ENTRIES];
    logic [IDX_W-1:0]    head_q, head_d;
    logic [IDX_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                    ready_int;
    logic                    alloc_fire;
    logic [CNT_W-1:0]        n_alloc;
    logic [CNT_W-1:0]        n_cmt;
    logic [COMMIT_WIDTH-1:0] scan_valid, scan_done, scan_exc, scan_cmt;
    logic                    scan_trap;
    ent_t                    new_ent;
    logic                    unused_instr;

    // Space check uses start-of-cycle occupancy only.
    assign ready_int    = (count_q <= CNT_W'(ENTRIES - DISPATCH_WIDTH));
    assign alloc_fire   = ready_int & (|disp_valid_i) & ~flush_i;
    assign disp_ready_o = rst | ready_int;

    always_comb begin
        unused_instr = 1'b0;
        n_alloc      = '0;
        for (int i = 0; i < int'(DISPATCH_WIDTH); i++) begin
            disp_idx_o[i] = tail_q + IDX_W'(i);
            n_alloc       = n_alloc + CNT_W'(disp_valid_i[i]);
            unused_instr  = unused_instr ^ (^disp_entry_i[i].instr);
        end
    end

    always_comb begin
        scan_valid  = '0;
        scan_done   = '0;
        scan_exc    = '0;
        cmt_entry_o = '0;
        for (int k = 0; k < int'(COMMIT_WIDTH); k++) begin
            scan_valid[k]              = ent_q[head_q + IDX_W'(k)].valid;
            scan_done[k]               = ent_q[head_q + IDX_W'(k)].done;
            scan_exc[k]                = ent_q[head_q + IDX_W'(k)].exc;
            cmt_entry_o[k].rd_arch     = ent_q[head_q + IDX_W'(k)].rd_arch;
            cmt_entry_o[k].rd_phys_old = ROB_PTAG_W'(ent_q[head_q + IDX_W'(k)].rd_phys_old);
            cmt_entry_o[k].result      = ROB_XLEN'(ent_q[head_q + IDX_W'(k)].result);
            cmt_entry_o[k].pc          = ROB_XLEN'(ent_q[head_q + IDX_W'(k)].pc);
            cmt_entry_o[k].is_branch   = ent_q[head_q + IDX_W'(k)].is_branch;
            cmt_entry_o[k].is_load     = ent_q[head_q + IDX_W'(k)].is_load;
            cmt_entry_o[k].is_store    = ent_q[head_q + IDX_W'(k)].is_store;
        end
    end

    rob_commit_scan #(
        .WIDTH (COMMIT_WIDTH)
    ) u_scan (
        .valid_i     (scan_valid),
        .done_i      (scan_done),
        .exc_i       (scan_exc),
        .cmt_valid_c (scan_cmt),
        .trap_c      (scan_trap)
    );

    // Retire and trap are suppressed while the buffer is being cleared.
    assign cmt_valid_o  = scan_cmt & {COMMIT_WIDTH{~(flush_i | rst)}};
    assign trap_valid_o = scan_trap & ~rst;
    assign trap_pc_o    = rst ? '0 : ent_q[head_q].pc;
    assign trap_cause_o = rst ? '0 : ent_q[head_q].cause;
    assign count_o      = rst ? '0 : count_q;
    assign empty_o      = (count_o == '0);

    always_comb begin
        n_cmt = '0;
        for (int k = 0; k < int'(COMMIT_WIDTH); k++) begin
            n_cmt = n_cmt + CNT_W'(cmt_valid_o[k]);
        end
    end

    // Next state: writeback, then retire clear, then allocate; flush overrides all.
    always_comb begin
        ent_d   = ent_q;
        head_d  = head_q + IDX_W'(n_cmt);
        tail_d  = tail_q;
        count_d = count_q - n_cmt;
        new_ent = '0;

        for (int p = 0; p < int'(WB_PORTS); p++) begin
            if (wb_valid_i[p] && ent_q[wb_idx_i[p]].valid) begin
                ent_d[wb_idx_i[p]].done   = 1'b1;
                ent_d[wb_idx_i[p]].result = wb_data_i[p];
                ent_d[wb_idx_i[p]].exc    = wb_exc_i[p];
                ent_d[wb_idx_i[p]].cause  = wb_cause_i[p];
            end
        end

        for (int k = 0; k < int'(COMMIT_WIDTH); k++) begin
            if (cmt_valid_o[k]) begin
                ent_d[head_q + IDX_W'(k)].valid = 1'b0;
                ent_d[head_q + IDX_W'(k)].done  = 1'b0;
                ent_d[head_q + IDX_W'(k)].exc   = 1'b0;
            end
        end

        if (alloc_fire) begin
            for (int i = 0; i < int'(DISPATCH_WIDTH); i++) begin
                if (disp_valid_i[i]) begin
                    new_ent             = '0;
                    new_ent.valid       = 1'b1;
                    new_ent.is_branch   = disp_entry_i[i].is_branch;
                    new_ent.is_load     = disp_entry_i[i].is_load;
                    new_ent.is_store    = disp_entry_i[i].is_store;
                    new_ent.rd_arch     = disp_entry_i[i].rd_arch;
                    new_ent.rd_phys_old = PTAG_W'(disp_entry_i[i].rd_phys_old);
                    new_ent.pc          = XLEN'(disp_entry_i[i].pc);
                    ent_d[tail_q + IDX_W'(i)] = new_ent;
                end
            end
            tail_d  = tail_q + IDX_W'(n_alloc);
            count_d = count_q - n_cmt + n_alloc;
        end

        if (flush_i) begin
            for (int e = 0; e < int'(ENTRIES); e++) begin
                ent_d[e].valid = 1'b0;
                ent_d[e].done  = 1'b0;
                ent_d[e].exc   = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < int'(ENTRIES); e++) begin
                ent_q[e] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int e = 0; e < int'(ENTRIES); e++) begin
                ent_q[e] <= ent_d[e];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: doc/supernova_rob_mw.md
Name: supernova_rob_mw

Overview:
Parametrised multi-wide Reorder Buffer for the Supernova OoO core, sitting between rename/dispatch and the architectural commit stage. It allocates up to DISPATCH_WIDTH entries per cycle and absorbs up to WB_PORTS completion writebacks per cycle. It retires up to COMMIT_WIDTH done entries in order, and raises a precise trap when the oldest entry carries an exception. It generalises the single-entry ROB record to a full circular buffer with flush and trap handling.

Parameters:
ENTRIES, 128, ROB depth; power of two, >= 2*DISPATCH_WIDTH
DISPATCH_WIDTH, 4, allocation lanes per cycle
COMMIT_WIDTH, 4, retire lanes per cycle
WB_PORTS, 4, completion writeback ports
XLEN, 64, data/pc width
PTAG_W, 7, physical register tag width
IDX_W, $clog2(ENTRIES), ROB index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush_i  in  1  clear all entries (pipeline redirect/trap taken)
disp_valid_i  in  DISPATCH_WIDTH  per-lane allocate request; compacted (lane i set implies lane i-1 set)
disp_ready_o  out  1  high when free entries >= DISPATCH_WIDTH
disp_entry_i  in  DISPATCH_WIDTH x rob_alloc_t  pc, instr, rd_arch, rd_phys_old, is_branch/is_load/is_store
disp_idx_o  out  DISPATCH_WIDTH x IDX_W  assigned index per lane (tail+i), combinational
wb_valid_i  in  WB_PORTS  writeback strobe
wb_idx_i  in  WB_PORTS x IDX_W  target entry
wb_data_i  in  WB_PORTS x XLEN  result
wb_exc_i  in  WB_PORTS  exception flag
wb_cause_i  in  WB_PORTS x XLEN  trap cause
cmt_valid_o  out  COMMIT_WIDTH  retiring lanes (compacted)
cmt_entry_o  out  COMMIT_WIDTH x rob_commit_t  rd_arch, rd_phys_old, result, pc, flags
trap_valid_o  out  1  head entry is done with exception
trap_pc_o  out  XLEN  pc of trapping entry
trap_cause_o  out  XLEN  cause of trapping entry
count_o  out  IDX_W+1  occupied entries
empty_o  out  1  count_o == 0

Behaviour:
- Reset (rst high at posedge): head=tail=0, count=0, all valid/done bits cleared. While in reset: disp_ready_o=1, cmt_valid_o=0, trap_valid_o=0, trap_pc_o=0, trap_cause_o=0, count_o=0, empty_o=1. Reset mid-operation discards all state with no commits.
- Allocation: all-or-nothing. When disp_ready_o && any disp_valid_i, lane i writes entry tail+i (mod ENTRIES) with valid=1, done=0, exc=0. Tail advances by popcount(disp_valid_i). disp_valid_i while !disp_ready_o is ignored; nothing is written.
- disp_ready_o uses start-of-cycle count. Same-cycle commits do not enlarge space.
- Writeback: sets done=1 and stores data/exc/cause at the next posedge. Writeback to an entry with valid=0 is ignored. Two ports hitting the same idx in one cycle: the highest-numbered port wins. Writeback to an entry being allocated in the same cycle is ignored.
- Commit (combinational from registered state): lane k is valid iff entries head..head+k are all valid, done and exc=0. Commit stops at the first not-done or excepting entry. Head advances by popcount(cmt_valid_o) at posedge; those entries are cleared.
- Trap: trap_valid_o=1 when the head entry is valid, done and exc=1; in that case cmt_valid_o=0. The trap holds until flush_i. The ROB never flushes itself.
- flush_i: at posedge, head=tail=count=0 and all valid cleared. Flush has priority over same-cycle dispatch, writeback and commit, and cmt_valid_o is forced to 0 during the flush cycle.
- count_next = count + allocated - committed. Pointers wrap mod ENTRIES via natural IDX_W overflow. Full is reached when count==ENTRIES.
- Latency: an entry written back at cycle N can commit at cycle N+1. Dispatch-to-commit minimum is 2 cycles.

Decomposition:
- supernova_pkg gains rob_alloc_t, rob_commit_t, ROB_DISPATCH_WIDTH, ROB_COMMIT_WIDTH and ROB_WB_PORTS. The existing ROB_ENTRIES and ROB_IDX_WIDTH feed the defaults.
- One sub-module, rob_commit_scan: a combinational prefix scan over COMMIT_WIDTH head entries producing cmt_valid and the trap condition.

Test Plan:
- Reset, then dispatch 4 lanes with pc 0x1000..0x100C -> disp_idx_o=0..3, count_o=4. Write back idx 0,1,3 -> next cycle cmt_valid_o=0011, count_o=2.
- Fill to 128 entries -> disp_ready_o=0. A further dispatch is ignored (count stays 128). Commit 4 -> the next dispatch is accepted, tail wraps and lane idx = 0..3.
- Writeback idx 2 with wb_exc=1, cause=0x2, idx 0,1 done -> commit lanes 0,1 retire. Next cycle trap_valid_o=1, trap_pc_o=pc of idx 2, cmt_valid_o=0. Assert flush_i -> empty_o=1, trap_valid_o=0.
- Ports 0 and 3 both write idx 5 with data 0xAA and 0xBB -> committed result is 0xBB.
- flush_i in the same cycle as dispatch of 4 and writeback -> count_o=0, no commit, no entry written.
- Assert rst mid-stream with 60 entries live -> all outputs return to reset values, no commit emitted.
